frame_update_scheduler: RTL and testbench

//  Per-frame sequencer for game-object updates. On each Frame_Start (vblank) it steps, in fixed order, the

---
 rtl/frame_update_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_frame_update_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// Per-frame game-object update sequencer: player, bullet, alien (every Nth frame), collision.
// Optional feature macro: SCHED_PAUSE_EN (Pause input holds off new frames while idle).
module frame_update_scheduler #(
    parameter logic [3:0]  ALIEN_DIV = 4'd8,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Frame_Start,
    input  logic        Pause,
    input  logic        Div_Load,
    input  logic [3:0]  Alien_Div_In,
    input  logic        Player_Done,
    input  logic        Bullet_Done,
    input  logic        Alien_Done,
    input  logic        Collide_Done,
    output logic        Player_Step,
    output logic        Bullet_Step,
    output logic        Alien_Step,
    output logic        Collide_Step,
    output logic        Busy,
    output logic        Frame_Done,
    output logic [15:0] Frame_Count,
    output logic        Frame_Overrun,
    output logic [7:0]  Overrun_Cnt,
    output logic        Stall_Err,
    output logic [1:0]  Stall_Stage
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAYER  = 3'd1,
        S_BULLET  = 3'd2,
        S_ALIEN   = 3'd3,
        S_COLLIDE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wd_q, wd_d;
    logic [3:0]  fc_q, fc_d;
    logic [3:0]  div_q, div_d;
    logic [3:0]  step_q, step_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  overrun_cnt_q, overrun_cnt_d;
    logic        stall_err_q, stall_err_d;
    logic [1:0]  stall_stage_q, stall_stage_d;

    logic        busy_s, start_s, in_stage_s, stage_done_s;
    logic        done_ok_s, timeout_s, advance_s, alien_match_s;
    logic [1:0]  stage_code_s;

`ifdef SCHED_PAUSE_EN
    assign start_s = Frame_Start & ~Pause;
`else
    logic pause_unused_s;
    assign pause_unused_s = Pause;
    assign start_s        = Frame_Start;
`endif

    assign busy_s        = (state_q != S_IDLE);
    // A Done in the entry cycle (watchdog still 0) belongs to a previous request and is ignored.
    assign done_ok_s     = stage_done_s & (wd_q != 16'd0);
    assign timeout_s     = (wd_q == (TIMEOUT - 16'd1));
    assign advance_s     = in_stage_s & (done_ok_s | timeout_s);
    // fc beyond a freshly shrunk divider counts as a match so the formation never stalls.
    assign alien_match_s = (fc_q >= (div_q - 4'd1));

    // Decode which stage is active and select its Done input.
    always_comb begin
        in_stage_s   = 1'b1;
        stage_code_s = 2'd0;
        stage_done_s = 1'b0;
        case (state_q)
            S_PLAYER:  begin stage_code_s = 2'd0; stage_done_s = Player_Done;  end
            S_BULLET:  begin stage_code_s = 2'd1; stage_done_s = Bullet_Done;  end
            S_ALIEN:   begin stage_code_s = 2'd2; stage_done_s = Alien_Done;   end
            S_COLLIDE: begin stage_code_s = 2'd3; stage_done_s = Collide_Done; end
            default:   begin in_stage_s = 1'b0; end
        endcase
    end

    // Next-state, strobe, counter and error-flag logic.
    always_comb begin
        state_d       = state_q;
        wd_d          = 16'd0;
        fc_d          = fc_q;
        div_d         = div_q;
        step_d        = 4'b0000;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        overrun_d     = 1'b0;
        overrun_cnt_d = overrun_cnt_q;
        stall_err_d   = stall_err_q;
        stall_stage_d = stall_stage_q;

        if (Div_Load) begin
            div_d = (Alien_Div_In == 4'd0) ? 4'd1 : Alien_Div_In;
        end else begin
            div_d = div_q;
        end

        if (advance_s && !done_ok_s) begin
            stall_err_d   = 1'b1;
            stall_stage_d = stall_err_q ? stall_stage_q : stage_code_s;
        end else begin
            stall_err_d   = stall_err_q;
        end

        if (Frame_Start && busy_s) begin
            overrun_d     = 1'b1;
            overrun_cnt_d = (overrun_cnt_q == 8'd255) ? 8'd255 : (overrun_cnt_q + 8'd1);
        end else begin
            overrun_d     = 1'b0;
        end

        // Watchdog resets to 0 on every transition, otherwise counts cycles spent in the stage.
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_PLAYER;
                    step_d  = 4'b0001;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAYER: begin
                if (advance_s) begin
                    state_d = S_BULLET;
                    step_d  = 4'b0010;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_BULLET: begin
                if (advance_s && alien_match_s) begin
                    state_d = S_ALIEN;
                    step_d  = 4'b0100;
                    fc_d    = 4'd0;
                end else if (advance_s) begin
                    state_d = S_COLLIDE;
                    step_d  = 4'b1000;
                    fc_d    = fc_q + 4'd1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_ALIEN: begin
                if (advance_s) begin
                    state_d = S_COLLIDE;
                    step_d  = 4'b1000;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_COLLIDE: begin
                if (advance_s) begin
                    state_d       = S_IDLE;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            wd_q          <= 16'd0;
            fc_q          <= 4'd0;
            div_q         <= ALIEN_DIV;
            step_q        <= 4'b0000;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 8'd0;
            stall_err_q   <= 1'b0;
            stall_stage_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            fc_q          <= fc_d;
            div_q         <= div_d;
            step_q        <= step_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
            stall_err_q   <= stall_err_d;
            stall_stage_q <= stall_stage_d;
        end
    end

    assign Player_Step   = step_q[0];
    assign Bullet_Step   = step_q[1];
    assign Alien_Step    = step_q[2];
    assign Collide_Step  = step_q[3];
    assign Busy          = busy_s;
    assign Frame_Done    = frame_done_q;
    assign Frame_Count   = frame_count_q;
    assign Frame_Overrun = overrun_q;
    assign Overrun_Cnt   = overrun_cnt_q;
    assign Stall_Err     = stall_err_q;
    assign Stall_Stage   = stall_stage_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: a scoreboard of expected step/frame-done events
// with their cycle numbers, an auto-responder pulsing Done 3 cycles after each Step.
module tb_frame_update_scheduler;

    localparam int TO = 20;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Frame_Start = 1'b0;
    logic        Pause = 1'b0;
    logic        Div_Load = 1'b0;
    logic [3:0]  Alien_Div_In = 4'd0;
    logic        Player_Done = 1'b0, Bullet_Done = 1'b0, Alien_Done = 1'b0, Collide_Done = 1'b0;
    logic        Player_Step, Bullet_Step, Alien_Step, Collide_Step, Busy, Frame_Done;
    logic [15:0] Frame_Count;
    logic        Frame_Overrun;
    logic [7:0]  Overrun_Cnt;
    logic        Stall_Err;
    logic [1:0]  Stall_Stage;

    frame_update_scheduler #(.ALIEN_DIV(4'd8), .TIMEOUT(16'd20)) dut (
        .Clk(Clk), .Reset(Reset), .Frame_Start(Frame_Start), .Pause(Pause),
        .Div_Load(Div_Load), .Alien_Div_In(Alien_Div_In),
        .Player_Done(Player_Done), .Bullet_Done(Bullet_Done),
        .Alien_Done(Alien_Done), .Collide_Done(Collide_Done),
        .Player_Step(Player_Step), .Bullet_Step(Bullet_Step),
        .Alien_Step(Alien_Step), .Collide_Step(Collide_Step),
        .Busy(Busy), .Frame_Done(Frame_Done), .Frame_Count(Frame_Count),
        .Frame_Overrun(Frame_Overrun), .Overrun_Cnt(Overrun_Cnt),
        .Stall_Err(Stall_Err), .Stall_Stage(Stall_Stage)
    );

    always #5 Clk = ~Clk;

    typedef struct { int stage; int cyc; } ev_t;
    ev_t  sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cd[4] = '{0, 0, 0, 0};
    logic [3:0] resp_en = 4'hF;

    // Reference model state
    int m_div = 8, m_fc = 0, m_frames = 0, m_ovr = 0, m_stall = 0, m_stall_stage = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic pop_event(input int s);
        ev_t e;
        chk("sb_has_entry", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("event_stage", s, e.stage);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor and Done responder, 1 time unit after each rising edge.
    always @(posedge Clk) begin
        logic [3:0] steps;
        logic [3:0] done_v;
        #1;
        cyc = cyc + 1;
        done_v = 4'b0000;
        steps  = {Collide_Step, Alien_Step, Bullet_Step, Player_Step};
        for (int s = 0; s < 4; s++) begin
            if (Reset) begin
                cd[s] = 0;
            end else if (cd[s] > 0) begin
                cd[s] = cd[s] - 1;
                if (cd[s] == 0 && resp_en[s]) done_v[s] = 1'b1;
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (steps[s] === 1'b1) begin
                pop_event(s);
                cd[s] = 3;
            end
        end
        if (Frame_Done === 1'b1) pop_event(4);
        Player_Done  = done_v[0];
        Bullet_Done  = done_v[1];
        Alien_Done   = done_v[2];
        Collide_Done = done_v[3];
    end

    // One full frame; en masks which stages answer with Done, n_drop extra Frame_Starts land mid-sequence.
    task automatic run_frame(input int n_drop, input logic [3:0] en);
        int  c, t, fin;
        int  seq[$];
        resp_en = en;
        seq = {0, 1};
        if (m_fc >= m_div - 1) begin
            seq.push_back(2);
            m_fc = 0;
        end else begin
            m_fc = m_fc + 1;
        end
        seq.push_back(3);
        c = cyc;
        t = c + 1;
        foreach (seq[i]) begin
            sb.push_back('{seq[i], t});
            if (en[seq[i]]) begin
                t = t + 4;
            end else begin
                t = t + TO;
                if (m_stall == 0) m_stall_stage = seq[i];
                m_stall = 1;
            end
        end
        sb.push_back('{4, t});
        m_frames = (m_frames + 1) % 65536;
        Frame_Start = 1'b1;
        fin = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 1) chk("busy_in_frame", Busy, 1);
            if (k >= 3 && k <= n_drop + 2) chk("overrun_pulse", Frame_Overrun, 1);
            if (Frame_Done === 1'b1) begin
                fin = 1;
                break;
            end
            Frame_Start = (k >= 2 && k <= n_drop + 1);
            if (Frame_Start) m_ovr = (m_ovr == 255) ? 255 : m_ovr + 1;
        end
        Frame_Start = 1'b0;
        chk("frame_completed", fin, 1);
        chk("busy_after_frame", Busy, 0);
        chk("frame_count", Frame_Count, m_frames);
        chk("sb_drained", sb.size(), 0);
        chk("overrun_cnt", Overrun_Cnt, m_ovr);
        chk("stall_err", Stall_Err, m_stall);
        chk("stall_stage", Stall_Stage, m_stall_stage);
    endtask

    task automatic load_div(input logic [3:0] v);
        Alien_Div_In = v;
        Div_Load = 1'b1;
        tick();
        Div_Load = 1'b0;
        m_div = (v == 4'd0) ? 1 : int'(v);
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {Player_Step, Bullet_Step, Alien_Step, Collide_Step, Busy, Frame_Done,
                  Frame_Overrun, Stall_Err, Stall_Stage}, 0);
        chk({tag, "_counts"}, {Frame_Count, Overrun_Cnt}, 0);
    endtask

    initial begin
        int c;
        repeat (3) tick();
        check_all_zero("reset_held");
        Reset = 1'b0;
        repeat (6) tick();
        check_all_zero("reset_released");

        // Eight frames at divider 8: alien only on the eighth
        for (int f = 0; f < 8; f++) run_frame(0, 4'hF);
        tick();

        // Divider 2: alien in every second frame
        load_div(4'd2);
        for (int f = 0; f < 4; f++) run_frame(0, 4'hF);

        // Single dropped frame while in the sequence
        run_frame(1, 4'hF);

        // Bullet never done, then collide never done: first stalled stage is kept
        run_frame(0, 4'b1101);
        run_frame(0, 4'b0111);

        // Many drops: counter saturates
        for (int f = 0; f < 30; f++) run_frame(10, 4'hF);
        chk("overrun_saturated", Overrun_Cnt, 255);

        // Divider 0 acts as 1; reset asynchronously while in the alien stage
        load_div(4'd0);
        resp_en = 4'hF;
        c = cyc;
        sb.push_back('{0, c + 1});
        sb.push_back('{1, c + 5});
        sb.push_back('{2, c + 9});
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
        repeat (8) tick();
        chk("in_alien_stage", Alien_Step, 1);
        tick();
        Reset = 1'b1;
        #1;
        check_all_zero("async_reset_mid_alien");
        sb.delete();
        m_div = 8; m_fc = 0; m_frames = 0; m_ovr = 0; m_stall = 0; m_stall_stage = 0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        run_frame(0, 4'hF);

`ifdef SCHED_PAUSE_EN
        Pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Frame_Start = 1'b1;
            tick();
            Frame_Start = 1'b0;
            tick();
            chk("paused_not_busy", Busy, 0);
        end
        repeat (3) tick();
        chk("paused_overrun", Overrun_Cnt, m_ovr);
        chk("paused_count", Frame_Count, m_frames);
        Pause = 1'b0;
        tick();
        run_frame(0, 4'hF);
`else
        Pause = 1'b1;
        run_frame(0, 4'hF);
        Pause = 1'b0;
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
